// File: rtl/execute_pkg.sv
// Encodings shared by the E stage and the control unit: opcodes, functs,
// MDU operations, Tnew levels and the instruction classifier.
package execute_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1a;
   localparam logic [5:0] FN_DIVU  = 6'h1b;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [1:0] TNEW_0 = 2'd0;
   localparam logic [1:0] TNEW_1 = 2'd1;
   localparam logic [1:0] TNEW_2 = 2'd2;

   typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;
   typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

   typedef enum logic [4:0] {
      INS_NOP, INS_ADDU, INS_SUBU, INS_ORI, INS_LUI, INS_LW, INS_SW, INS_BEQ,
      INS_JAL, INS_MULT, INS_MULTU, INS_DIV, INS_DIVU, INS_MFHI, INS_MFLO,
      INS_MTHI, INS_MTLO
   } ins_e;

   // Anything not recognised collapses to a bubble.
   function automatic ins_e decode_ins(input logic [5:0] opcode, input logic [5:0] funct);
      ins_e kind;
      kind = INS_NOP;
      case (opcode)
         OP_SPECIAL: begin
            case (funct)
               FN_ADDU:  kind = INS_ADDU;
               FN_SUBU:  kind = INS_SUBU;
               FN_MULT:  kind = INS_MULT;
               FN_MULTU: kind = INS_MULTU;
               FN_DIV:   kind = INS_DIV;
               FN_DIVU:  kind = INS_DIVU;
               FN_MFHI:  kind = INS_MFHI;
               FN_MFLO:  kind = INS_MFLO;
               FN_MTHI:  kind = INS_MTHI;
               FN_MTLO:  kind = INS_MTLO;
               default:  kind = INS_NOP;
            endcase
         end
         OP_ORI:  kind = INS_ORI;
         OP_LUI:  kind = INS_LUI;
         OP_LW:   kind = INS_LW;
         OP_SW:   kind = INS_SW;
         OP_BEQ:  kind = INS_BEQ;
         OP_JAL:  kind = INS_JAL;
         default: kind = INS_NOP;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/execute_mdu.sv
// Multiply/divide unit: latches operands on start, counts down a fixed latency,
// then commits HI/LO. mthi/mtlo write directly while idle.
module E_MDU
   import execute_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  md_op_e      op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        mthi,
   input  logic        mtlo,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      hi_q, lo_q, a_q, b_q;
   md_op_e           op_q;

   logic [31:0] hi_d, lo_d;
   logic [63:0] prod;
   logic [31:0] mag_a, mag_b, quo, rem;
   logic        neg_a, neg_b;

   // Result is formed from the latched operands; it is only committed on the last busy cycle.
   always_comb begin
      prod  = '0;
      mag_a = a_q;
      mag_b = b_q;
      neg_a = 1'b0;
      neg_b = 1'b0;
      quo   = '0;
      rem   = '0;
      hi_d  = hi_q;
      lo_d  = lo_q;
      case (op_q)
         MD_MULT: begin
            prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
            {hi_d, lo_d} = prod;
         end
         MD_MULTU: begin
            prod = {32'd0, a_q} * {32'd0, b_q};
            {hi_d, lo_d} = prod;
         end
         default: begin
            neg_a = (op_q == MD_DIV) & a_q[31];
            neg_b = (op_q == MD_DIV) & b_q[31];
            mag_a = neg_a ? -a_q : a_q;
            mag_b = neg_b ? -b_q : b_q;
            if (b_q != '0) begin
               quo  = mag_a / mag_b;
               rem  = mag_a % mag_b;
               lo_d = (neg_a ^ neg_b) ? -quo : quo;
               hi_d = neg_a ? -rem : rem;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= MD_MULT;
      end else begin
         case (state_q)
            MD_IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  op_q    <= op;
                  cnt_q   <= (op == MD_MULT || op == MD_MULTU) ? CNT_W'(MULT_CYCLES)
                                                               : CNT_W'(DIV_CYCLES);
                  state_q <= MD_BUSY;
               end else begin
                  if (mthi) hi_q <= A;
                  if (mtlo) lo_q <= A;
               end
            end
            default: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  hi_q    <= hi_d;
                  lo_q    <= lo_d;
                  state_q <= MD_IDLE;
               end
            end
         endcase
      end
   end

   assign busy = reset & ((state_q == MD_BUSY) | start);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: rtl/execute.sv
// E pipeline stage: decode, ALU, forwarding source, MDU and the E/M register.
module execute
   import execute_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] E_PC,
   input  logic [31:0] E_Ins,
   input  logic        E_branchTrue,
   input  logic [31:0] E_rs_fw,
   input  logic [31:0] E_rt_fw,
   output logic [4:0]  E_rs,
   output logic [4:0]  E_rt,
   output logic [1:0]  E_Tnew,
   output logic [4:0]  E_GRF_WA,
   output logic [31:0] E_GRF_WD,
   output logic        E_MD_busy,
   output logic        E_MD_use,
   output logic [31:0] M_PC,
   output logic [31:0] M_Ins,
   output logic [31:0] M_ALU_Y,
   output logic [31:0] M_rt_data,
   output logic        M_branchTrue
);

   ins_e        ins_kind;
   logic [4:0]  rd;
   logic [31:0] imm_zext, imm_sext;
   logic [31:0] hi, lo, alu_y_d;
   logic        md_start, md_mthi, md_mtlo;
   md_op_e      md_op;

   logic [31:0] m_pc_q, m_ins_q, m_alu_y_q, m_rt_data_q;
   logic        m_branch_q;

   assign ins_kind = decode_ins(E_Ins[31:26], E_Ins[5:0]);
   assign E_rs     = E_Ins[25:21];
   assign E_rt     = E_Ins[20:16];
   assign rd       = E_Ins[15:11];
   assign imm_zext = {16'd0, E_Ins[15:0]};
   assign imm_sext = {{16{E_Ins[15]}}, E_Ins[15:0]};

   always_comb begin
      alu_y_d  = '0;
      E_GRF_WA = '0;
      E_GRF_WD = '0;
      E_Tnew   = TNEW_0;
      E_MD_use = 1'b0;
      md_start = 1'b0;
      md_mthi  = 1'b0;
      md_mtlo  = 1'b0;
      md_op    = MD_MULT;
      case (ins_kind)
         INS_ADDU:  begin alu_y_d = E_rs_fw + E_rt_fw; E_GRF_WA = rd;   E_Tnew = TNEW_1; end
         INS_SUBU:  begin alu_y_d = E_rs_fw - E_rt_fw; E_GRF_WA = rd;   E_Tnew = TNEW_1; end
         INS_ORI:   begin alu_y_d = E_rs_fw | imm_zext; E_GRF_WA = E_rt; E_Tnew = TNEW_1; end
         INS_LUI:   begin alu_y_d = {E_Ins[15:0], 16'd0}; E_GRF_WA = E_rt; E_Tnew = TNEW_1; end
         INS_LW:    begin alu_y_d = E_rs_fw + imm_sext; E_GRF_WA = E_rt; E_Tnew = TNEW_2; end
         INS_SW:    alu_y_d = E_rs_fw + imm_sext;
         INS_JAL:   begin E_GRF_WA = 5'd31; E_GRF_WD = E_PC + 32'd8; end
         INS_MFHI:  begin alu_y_d = hi; E_GRF_WA = rd; E_Tnew = TNEW_1; E_MD_use = 1'b1; end
         INS_MFLO:  begin alu_y_d = lo; E_GRF_WA = rd; E_Tnew = TNEW_1; E_MD_use = 1'b1; end
         INS_MTHI:  begin E_MD_use = 1'b1; md_mthi = 1'b1; end
         INS_MTLO:  begin E_MD_use = 1'b1; md_mtlo = 1'b1; end
         INS_MULT:  begin E_MD_use = 1'b1; md_start = 1'b1; md_op = MD_MULT;  end
         INS_MULTU: begin E_MD_use = 1'b1; md_start = 1'b1; md_op = MD_MULTU; end
         INS_DIV:   begin E_MD_use = 1'b1; md_start = 1'b1; md_op = MD_DIV;   end
         INS_DIVU:  begin E_MD_use = 1'b1; md_start = 1'b1; md_op = MD_DIVU;  end
         default: ;
      endcase
   end

   E_MDU #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_mdu (
      .clk   (clk),
      .reset (reset),
      .start (md_start),
      .op    (md_op),
      .A     (E_rs_fw),
      .B     (E_rt_fw),
      .mthi  (md_mthi),
      .mtlo  (md_mtlo),
      .busy  (E_MD_busy),
      .HI    (hi),
      .LO    (lo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc_q      <= '0;
         m_ins_q     <= '0;
         m_alu_y_q   <= '0;
         m_rt_data_q <= '0;
         m_branch_q  <= 1'b0;
      end else begin
         m_pc_q      <= E_PC;
         m_ins_q     <= E_Ins;
         m_alu_y_q   <= alu_y_d;
         m_rt_data_q <= E_rt_fw;
         m_branch_q  <= E_branchTrue;
      end
   end

   assign M_PC         = m_pc_q;
   assign M_Ins        = m_ins_q;
   assign M_ALU_Y      = m_alu_y_q;
   assign M_rt_data    = m_rt_data_q;
   assign M_branchTrue = m_branch_q;

endmodule

// File: tb/tb_execute.sv
// Bench for the E stage: directed MDU/ALU scenarios plus random instruction
// streams, all checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_execute;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] E_PC = '0, E_Ins = '0, E_rs_fw = '0, E_rt_fw = '0;
   logic        E_branchTrue = 1'b0;
   logic [4:0]  E_rs, E_rt, E_GRF_WA;
   logic [1:0]  E_Tnew;
   logic [31:0] E_GRF_WD, M_PC, M_Ins, M_ALU_Y, M_rt_data;
   logic        E_MD_busy, E_MD_use, M_branchTrue;

   always #5 clk = ~clk;

   execute #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .E_PC(E_PC), .E_Ins(E_Ins), .E_branchTrue(E_branchTrue),
      .E_rs_fw(E_rs_fw), .E_rt_fw(E_rt_fw), .E_rs(E_rs), .E_rt(E_rt), .E_Tnew(E_Tnew),
      .E_GRF_WA(E_GRF_WA), .E_GRF_WD(E_GRF_WD), .E_MD_busy(E_MD_busy), .E_MD_use(E_MD_use),
      .M_PC(M_PC), .M_Ins(M_Ins), .M_ALU_Y(M_ALU_Y), .M_rt_data(M_rt_data),
      .M_branchTrue(M_branchTrue)
   );

   localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_ORI = 3, K_LUI = 4, K_LW = 5, K_SW = 6,
                  K_BEQ = 7, K_JAL = 8, K_MULT = 9, K_MULTU = 10, K_DIV = 11, K_DIVU = 12,
                  K_MFHI = 13, K_MFLO = 14, K_MTHI = 15, K_MTLO = 16;

   int n_vec = 0, n_err = 0, cyc = 0;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        p_valid, last_busy;
   int          md_left;
   logic [31:0] x_pc, x_ins, x_alu, x_rt;
   logic        x_br;

   function automatic int kind_of(input logic [31:0] w);
      if (w[31:26] == 6'h00) begin
         case (w[5:0])
            6'h21: return K_ADDU;  6'h23: return K_SUBU;
            6'h18: return K_MULT;  6'h19: return K_MULTU;
            6'h1a: return K_DIV;   6'h1b: return K_DIVU;
            6'h10: return K_MFHI;  6'h12: return K_MFLO;
            6'h11: return K_MTHI;  6'h13: return K_MTLO;
            default: return K_NOP;
         endcase
      end
      case (w[31:26])
         6'h0d: return K_ORI;  6'h0f: return K_LUI;  6'h23: return K_LW;
         6'h2b: return K_SW;   6'h04: return K_BEQ;  6'h03: return K_JAL;
         default: return K_NOP;
      endcase
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] ref_alu(input logic [31:0] w, input logic [31:0] rsv,
                                           input logic [31:0] rtv);
      case (kind_of(w))
         K_ADDU:      return rsv + rtv;
         K_SUBU:      return rsv - rtv;
         K_ORI:       return rsv | {16'd0, w[15:0]};
         K_LUI:       return {w[15:0], 16'd0};
         K_LW, K_SW:  return rsv + {{16{w[15]}}, w[15:0]};
         K_MFHI:      return m_hi;
         K_MFLO:      return m_lo;
         default:     return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_wa(input logic [31:0] w);
      case (kind_of(w))
         K_ADDU, K_SUBU, K_MFHI, K_MFLO: return {27'd0, w[15:11]};
         K_ORI, K_LUI, K_LW:             return {27'd0, w[20:16]};
         K_JAL:                          return 32'd31;
         default:                        return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_tnew(input logic [31:0] w);
      case (kind_of(w))
         K_LW:                                   return 32'd2;
         K_ADDU, K_SUBU, K_ORI, K_LUI, K_MFHI, K_MFLO: return 32'd1;
         default:                                return 32'd0;
      endcase
   endfunction

   function automatic logic is_start(input logic [31:0] w);
      int k;
      k = kind_of(w);
      return (k >= K_MULT && k <= K_DIVU);
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_valid = 1'b0; md_left = 0;
      x_pc = '0; x_ins = '0; x_alu = '0; x_rt = '0; x_br = 1'b0;
   endtask

   // What one rising edge does, from the instruction's architectural meaning.
   task automatic model_edge(input logic [31:0] w, input logic [31:0] rsv, input logic [31:0] rtv,
                             input logic [31:0] pc, input logic br);
      longint sa, sb, ps;
      longint unsigned ua, ub, pu;
      int k;
      k = kind_of(w);
      x_alu = ref_alu(w, rsv, rtv);
      x_pc = pc; x_ins = w; x_rt = rtv; x_br = br;
      sa = $signed(rsv); sb = $signed(rtv);
      ua = rsv; ub = rtv;
      if (md_left > 0) begin
         md_left--;
         if (md_left == 0 && p_valid) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (k == K_MULT) begin
         ps = sa * sb; p_hi = ps[63:32]; p_lo = ps[31:0]; p_valid = 1'b1; md_left = 5;
      end else if (k == K_MULTU) begin
         pu = ua * ub; p_hi = pu[63:32]; p_lo = pu[31:0]; p_valid = 1'b1; md_left = 5;
      end else if (k == K_DIV) begin
         p_valid = (rtv != 0);
         if (p_valid) begin
            ps = sa / sb; p_lo = ps[31:0];
            ps = sa % sb; p_hi = ps[31:0];
         end
         md_left = 10;
      end else if (k == K_DIVU) begin
         p_valid = (rtv != 0);
         if (p_valid) begin p_lo = rsv / rtv; p_hi = rsv % rtv; end
         md_left = 10;
      end else if (k == K_MTHI) begin
         m_hi = rsv;
      end else if (k == K_MTLO) begin
         m_lo = rsv;
      end
   endtask

   task automatic check_outputs(input logic [31:0] w, input logic [31:0] pc);
      logic exp_busy, exp_use;
      exp_busy = (md_left > 0) || is_start(w);
      exp_use  = (kind_of(w) >= K_MULT);
      cmp("E_rs", E_rs, w[25:21]);
      cmp("E_rt", E_rt, w[20:16]);
      cmp("E_Tnew", E_Tnew, ref_tnew(w));
      cmp("E_GRF_WA", E_GRF_WA, ref_wa(w));
      cmp("E_GRF_WD", E_GRF_WD, (kind_of(w) == K_JAL) ? pc + 32'd8 : 32'd0);
      cmp("E_MD_busy", E_MD_busy, exp_busy);
      cmp("E_MD_use", E_MD_use, exp_use);
      cmp("M_PC", M_PC, x_pc);
      cmp("M_Ins", M_Ins, x_ins);
      cmp("M_ALU_Y", M_ALU_Y, x_alu);
      cmp("M_rt_data", M_rt_data, x_rt);
      cmp("M_branchTrue", M_branchTrue, x_br);
   endtask

   // Called just after a rising edge; applies one instruction for one cycle.
   task automatic step(input logic [31:0] w, input logic [31:0] rsv, input logic [31:0] rtv,
                       input logic [31:0] pc, input logic br);
      E_Ins = w; E_rs_fw = rsv; E_rt_fw = rtv; E_PC = pc; E_branchTrue = br;
      @(negedge clk);
      check_outputs(w, pc);
      last_busy = E_MD_busy;
      $display("cyc %0d pc=%h ins=%h rs=%h rt=%h busy=%b M_ALU_Y=%h",
               cyc, pc, w, rsv, rtv, E_MD_busy, M_ALU_Y);
      @(posedge clk); #1;
      model_edge(w, rsv, rtv, pc, br);
      cyc++;
   endtask

   task automatic md_run(input logic [31:0] w, input logic [31:0] rsv, input logic [31:0] rtv,
                         input int exp_cycles, input string name);
      int n;
      step(w, rsv, rtv, 32'h3000, 1'b0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(32'd0, 32'd0, 32'd0, 32'h3004, 1'b0);
         if (!last_busy) break;
         n++;
      end
      cmp(name, n, exp_cycles);
   endtask

   task automatic read_hilo(input logic [31:0] hi, input logic [31:0] lo, input string name);
      step(enc_r(5'd0, 5'd0, 5'd2, 6'h10), 32'd0, 32'd0, 32'h3100, 1'b0);
      cmp({name, "_hi"}, M_ALU_Y, hi);
      step(enc_r(5'd0, 5'd0, 5'd3, 6'h12), 32'd0, 32'd0, 32'h3104, 1'b0);
      cmp({name, "_lo"}, M_ALU_Y, lo);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w, rsv, rtv;
      logic [4:0]  f1, f2, f3;
      logic [15:0] imm;
      int          sel;
      logic [31:0] mult_w, div_w;
      model_reset();
      @(posedge clk); #1;
      cmp("rst_M_PC", M_PC, 32'd0);
      cmp("rst_M_ALU_Y", M_ALU_Y, 32'd0);
      cmp("rst_busy", E_MD_busy, 1'b0);
      reset = 1'b1;

      // jal and lw forwarding attributes
      step({6'h03, 26'h0000C00}, 32'd0, 32'd0, 32'h3000, 1'b1);
      cmp("jal_tnew", E_Tnew, 32'd0);
      cmp("jal_wa", E_GRF_WA, 32'd31);
      cmp("jal_wd", E_GRF_WD, 32'h3008);
      step(enc_i(6'h23, 5'd3, 5'd5, 16'hFFFC), 32'h10, 32'h77, 32'h3004, 1'b0);
      cmp("lw_tnew", E_Tnew, 32'd2);
      cmp("lw_alu", M_ALU_Y, 32'h0000_000C);

      mult_w = enc_r(5'd1, 5'd2, 5'd0, 6'h18);
      md_run(mult_w, 32'hFFFF_FFFF, 32'd2, 5, "mult_busy");
      read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
      md_run(enc_r(5'd1, 5'd2, 5'd0, 6'h19), 32'hFFFF_FFFF, 32'd2, 5, "multu_busy");
      read_hilo(32'h0000_0001, 32'hFFFF_FFFE, "multu");

      div_w = enc_r(5'd1, 5'd2, 5'd0, 6'h1a);
      md_run(div_w, 32'hFFFF_FFF9, 32'd2, 10, "div_busy");
      read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
      md_run(div_w, 32'h8000_0000, 32'hFFFF_FFFF, 10, "divovf_busy");
      read_hilo(32'h0000_0000, 32'h8000_0000, "divovf");
      md_run(enc_r(5'd1, 5'd2, 5'd0, 6'h1b), 32'd5, 32'd0, 10, "divu0_busy");
      read_hilo(32'h0000_0000, 32'h8000_0000, "divu0");

      // mthi while idle writes; mthi during a (divide-by-zero) busy period is dropped
      step(enc_r(5'd4, 5'd0, 5'd0, 6'h11), 32'h1234, 32'd0, 32'h3200, 1'b0);
      read_hilo(32'h0000_1234, 32'h8000_0000, "mthi");
      md_run(enc_r(5'd1, 5'd2, 5'd0, 6'h1b), 32'd9, 32'd0, 10, "divu0b_busy");
      step(enc_r(5'd1, 5'd2, 5'd0, 6'h1b), 32'd9, 32'd0, 32'h3300, 1'b0);
      step(enc_r(5'd4, 5'd0, 5'd0, 6'h11), 32'hAAAA, 32'd0, 32'h3304, 1'b0);
      for (int i = 0; i < 20 && md_left > 0; i++) step(32'd0, 32'd0, 32'd0, 32'h3308, 1'b0);
      read_hilo(32'h0000_1234, 32'h8000_0000, "mthi_busy");

      // asynchronous reset in the middle of a divide
      step(div_w, 32'hFFFF_FFF9, 32'd2, 32'h3400, 1'b0);
      step(enc_r(5'd1, 5'd2, 5'd3, 6'h21), 32'd3, 32'd4, 32'h0100, 1'b1);
      E_Ins = div_w;
      reset = 1'b0;
      #1;
      cmp("midrst_busy", E_MD_busy, 1'b0);
      cmp("midrst_M_PC", M_PC, 32'd0);
      cmp("midrst_M_Ins", M_Ins, 32'd0);
      cmp("midrst_M_ALU_Y", M_ALU_Y, 32'd0);
      cmp("midrst_M_rt", M_rt_data, 32'd0);
      cmp("midrst_M_br", M_branchTrue, 1'b0);
      model_reset();
      E_Ins = 32'd0;
      @(posedge clk); #1;
      reset = 1'b1;
      read_hilo(32'd0, 32'd0, "postrst");

      // random instruction stream; MD-class ops may land while busy and must be ignored
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 17);
         f1 = 5'($urandom); f2 = 5'($urandom); f3 = 5'($urandom); imm = 16'($urandom);
         case (sel)
            0:  w = enc_r(f1, f2, f3, 6'h21);
            1:  w = enc_r(f1, f2, f3, 6'h23);
            2:  w = enc_i(6'h0d, f1, f2, imm);
            3:  w = enc_i(6'h0f, f1, f2, imm);
            4:  w = enc_i(6'h23, f1, f2, imm);
            5:  w = enc_i(6'h2b, f1, f2, imm);
            6:  w = enc_i(6'h04, f1, f2, imm);
            7:  w = {6'h03, 26'($urandom)};
            8:  w = enc_r(f1, f2, 5'd0, 6'h18);
            9:  w = enc_r(f1, f2, 5'd0, 6'h19);
            10: w = enc_r(f1, f2, 5'd0, 6'h1a);
            11: w = enc_r(f1, f2, 5'd0, 6'h1b);
            12: w = enc_r(5'd0, 5'd0, f3, 6'h10);
            13: w = enc_r(5'd0, 5'd0, f3, 6'h12);
            14: w = enc_r(f1, 5'd0, 5'd0, 6'h11);
            15: w = enc_r(f1, 5'd0, 5'd0, 6'h13);
            16: w = 32'd0;
            default: w = $urandom;
         endcase
         rsv = pick();
         rtv = pick();
         step(w, rsv, rtv, $urandom & 32'hFFFF_FFFC, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
